// File: rtl/shift_seq_reg_if.sv
// Bundle of the shift register's data, command and status signals.
// The slave modport is the register itself; the master modport is whoever drives commands.
interface shift_seq_reg_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic [WIDTH-1:0] i;
    logic             load;
    logic             start;
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic             serial_in;
    logic [WIDTH-1:0] q;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport slave (
        input  i, load, start, op, amt, serial_in,
        output q, serial_out, busy, done
    );

    modport master (
        output i, load, start, op, amt, serial_in,
        input  q, serial_out, busy, done
    );
endinterface

// File: rtl/shift_seq_reg.sv
// Universal shift register: parallel load, then a multi-step shift/rotate command
// executed one bit per clock under a start/busy/done handshake.
module shift_seq_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    shift_seq_reg_if.slave bus
);
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
    localparam logic [2:0] OP_SLI = 3'b101;
    localparam logic [2:0] OP_SRI = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    state_t           r_state, w_stateNext;
    logic [WIDTH-1:0] r_q, w_qNext, w_stepQ;
    logic             r_serialOut, w_serialOutNext, w_stepBit;
    logic             r_busy, w_busyNext;
    logic             r_done, w_doneNext;
    logic [2:0]       r_op, w_opNext;
    logic [AMT_W-1:0] r_cnt, w_cntNext;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_q         <= '0;
            r_serialOut <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_op        <= OP_NOP;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_q         <= w_qNext;
            r_serialOut <= w_serialOutNext;
            r_busy      <= w_busyNext;
            r_done      <= w_doneNext;
            r_op        <= w_opNext;
            r_cnt       <= w_cntNext;
        end
    end

    // One step of the latched operation; the ejected bit feeds serial_out.
    always_comb begin
        w_stepQ   = r_q;
        w_stepBit = r_serialOut;
        case (r_op)
            OP_SLL: begin w_stepQ = {r_q[WIDTH-2:0], 1'b0};          w_stepBit = r_q[WIDTH-1]; end
            OP_SRL: begin w_stepQ = {1'b0, r_q[WIDTH-1:1]};          w_stepBit = r_q[0];       end
            OP_SRA: begin w_stepQ = {r_q[WIDTH-1], r_q[WIDTH-1:1]};  w_stepBit = r_q[0];       end
            OP_ROL: begin w_stepQ = {r_q[WIDTH-2:0], r_q[WIDTH-1]};  w_stepBit = r_q[WIDTH-1]; end
            OP_ROR: begin w_stepQ = {r_q[0], r_q[WIDTH-1:1]};        w_stepBit = r_q[0];       end
            OP_SLI: begin w_stepQ = {r_q[WIDTH-2:0], bus.serial_in}; w_stepBit = r_q[WIDTH-1]; end
            OP_SRI: begin w_stepQ = {bus.serial_in, r_q[WIDTH-1:1]}; w_stepBit = r_q[0];       end
            default: begin w_stepQ = r_q; w_stepBit = r_serialOut; end
        endcase
    end

    always_comb begin
        w_stateNext     = r_state;
        w_qNext         = r_q;
        w_serialOutNext = r_serialOut;
        w_busyNext      = 1'b0;
        w_doneNext      = 1'b0;
        w_opNext        = r_op;
        w_cntNext       = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.load) begin
                    w_qNext = bus.i;
                end else if (bus.start) begin
                    w_opNext = bus.op;
                    if (bus.amt == '0 || bus.op == OP_NOP) begin
                        w_doneNext = 1'b1;
                    end else begin
                        w_stateNext = SHIFT;
                        w_cntNext   = bus.amt;
                        w_busyNext  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                w_qNext         = w_stepQ;
                w_serialOutNext = w_stepBit;
                w_cntNext       = r_cnt - 1'b1;
                // The final step hands control back to IDLE with a done pulse.
                if (r_cnt == AMT_W'(1)) begin
                    w_stateNext = IDLE;
                    w_doneNext  = 1'b1;
                end else begin
                    w_busyNext  = 1'b1;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign bus.q          = r_q;
    assign bus.serial_out = r_serialOut;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_shift_seq_reg.sv
// Directed bench for shift_seq_reg: hand-computed vectors for load, shifts,
// rotates, zero-length commands, ignored inputs while busy and mid-command reset.
module tb_shift_seq_reg;
    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic clk;
    logic reset;
    int   compareCount;
    int   mismatchCount;
    int   busyCycles;
    int   doneLatency;
    int   extraDone;

    shift_seq_reg_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    shift_seq_reg #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance past one rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadWord(input logic [WIDTH-1:0] value);
        bus.load = 1'b1;
        bus.i    = value;
        tick();
        bus.load = 1'b0;
    endtask

    // Issue a command and wait (bounded) for the done pulse, returning how many
    // busy cycles were seen and how many cycles after E0 done appeared.
    task automatic applyStimulus(input logic [2:0] opCode, input logic [AMT_W-1:0] amount,
                                 input logic serialIn, output int nBusy, output int latency);
        bus.start     = 1'b1;
        bus.op        = opCode;
        bus.amt       = amount;
        bus.serial_in = serialIn;
        tick();
        bus.start = 1'b0;
        nBusy     = 0;
        latency   = -1;
        for (int k = 0; k < 40; k++) begin
            if (bus.done) begin
                latency = k;
                checkOutput("busy_with_done", 32'(bus.busy), 32'd0);
                break;
            end
            if (bus.busy) nBusy++;
            tick();
        end
        if (latency < 0) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    // Count done pulses over a window where none should occur.
    task automatic countDone(input int cycles, output int nDone);
        nDone = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (bus.done) nDone++;
        end
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        reset         = 1'b1;
        bus.i         = '0;
        bus.load      = 1'b0;
        bus.start     = 1'b0;
        bus.op        = 3'b111;
        bus.amt       = '0;
        bus.serial_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst_q", 32'(bus.q), 32'h00);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_so", 32'(bus.serial_out), 32'd0);

        loadWord(8'hA5);
        checkOutput("load_q", 32'(bus.q), 32'hA5);
        checkOutput("load_busy", 32'(bus.busy), 32'd0);
        checkOutput("load_done", 32'(bus.done), 32'd0);
        checkOutput("load_so", 32'(bus.serial_out), 32'd0);

        applyStimulus(3'b000, 4'd3, 1'b0, busyCycles, doneLatency);
        checkOutput("sll3_q", 32'(bus.q), 32'h28);
        checkOutput("sll3_so", 32'(bus.serial_out), 32'd1);
        checkOutput("sll3_busy", 32'(busyCycles), 32'd3);
        checkOutput("sll3_lat", 32'(doneLatency), 32'd3);
        tick();
        checkOutput("sll3_pulse", 32'(bus.done), 32'd0);

        loadWord(8'h96);
        checkOutput("load_keeps_so", 32'(bus.serial_out), 32'd1);
        applyStimulus(3'b010, 4'd2, 1'b0, busyCycles, doneLatency);
        checkOutput("sra2_q", 32'(bus.q), 32'hE5);
        checkOutput("sra2_so", 32'(bus.serial_out), 32'd1);
        checkOutput("sra2_busy", 32'(busyCycles), 32'd2);

        loadWord(8'h81);
        applyStimulus(3'b100, 4'd9, 1'b0, busyCycles, doneLatency);
        checkOutput("ror9_q", 32'(bus.q), 32'hC0);
        checkOutput("ror9_so", 32'(bus.serial_out), 32'd1);
        checkOutput("ror9_busy", 32'(busyCycles), 32'd9);
        countDone(5, extraDone);
        checkOutput("ror9_done_once", 32'(extraDone), 32'd0);

        loadWord(8'hA5);
        applyStimulus(3'b011, 4'd4, 1'b0, busyCycles, doneLatency);
        checkOutput("rol4_q", 32'(bus.q), 32'h5A);
        applyStimulus(3'b001, 4'd3, 1'b0, busyCycles, doneLatency);
        checkOutput("srl3_q", 32'(bus.q), 32'h0B);
        checkOutput("srl3_so", 32'(bus.serial_out), 32'd0);

        loadWord(8'h00);
        applyStimulus(3'b101, 4'd10, 1'b1, busyCycles, doneLatency);
        checkOutput("sli10_q", 32'(bus.q), 32'hFF);
        checkOutput("sli10_busy", 32'(busyCycles), 32'd10);

        loadWord(8'h80);
        applyStimulus(3'b010, 4'd12, 1'b0, busyCycles, doneLatency);
        checkOutput("sra12_sat", 32'(bus.q), 32'hFF);

        loadWord(8'h00);
        applyStimulus(3'b110, 4'd4, 1'b1, busyCycles, doneLatency);
        checkOutput("sri4_q", 32'(bus.q), 32'hF0);
        checkOutput("sri4_so", 32'(bus.serial_out), 32'd0);
        // Issued in the done cycle to exercise back-to-back acceptance.
        applyStimulus(3'b110, 4'd0, 1'b1, busyCycles, doneLatency);
        checkOutput("amt0_lat", 32'(doneLatency), 32'd0);
        checkOutput("amt0_busy", 32'(busyCycles), 32'd0);
        checkOutput("amt0_q", 32'(bus.q), 32'hF0);
        applyStimulus(3'b111, 4'd5, 1'b0, busyCycles, doneLatency);
        checkOutput("nop_lat", 32'(doneLatency), 32'd0);
        checkOutput("nop_q", 32'(bus.q), 32'hF0);

        loadWord(8'hFF);
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.amt   = 4'd5;
        tick();
        bus.start = 1'b0;
        checkOutput("e0_q_unchanged", 32'(bus.q), 32'hFF);
        checkOutput("e0_busy", 32'(bus.busy), 32'd1);
        bus.load = 1'b1;
        bus.i    = 8'h00;
        tick();
        bus.load = 1'b0;
        checkOutput("busy_load_ignored", 32'(bus.q), 32'hFE);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrst_q", 32'(bus.q), 32'h00);
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_done", 32'(bus.done), 32'd0);
        checkOutput("midrst_so", 32'(bus.serial_out), 32'd0);
        countDone(10, extraDone);
        checkOutput("midrst_no_done", 32'(extraDone), 32'd0);
        checkOutput("midrst_idle", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
